// File: rtl/id_handler.sv
// rtl/id_handler.sv - user-ID entry and sequential user-ID ROM search
// Optional guest login for ID 0000 is built when ID_HANDLER_GUEST_LOGIN_EN is defined.
module id_handler #(
    parameter int NUM_USERS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  IdSwitch,
    input  logic        IdButton,
    input  logic        LogoutCommand_from_GC,
    input  logic [15:0] RomData,
    output logic [2:0]  RomAddress,
    output logic        MatchedID,
    output logic [2:0]  PlayerAddress_to_PH,
    output logic        IsGuest,
    output logic        IdBusy,
    output logic        IdError
);

    typedef enum logic [2:0] {
        ENTRY,
        FETCH,
        CATCH,
        COMPARE,
        MATCHED,
        NOMATCH
    } state_t;

    localparam logic [2:0] LAST_ADDR = 3'(NUM_USERS - 1);

    state_t      state;
    logic [15:0] EnteredId;
    logic [15:0] RomWord;
    logic [1:0]  DigitCount;

`ifndef ID_HANDLER_GUEST_LOGIN_EN
    assign IsGuest = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ENTRY;
            EnteredId           <= 16'h0000;
            RomWord             <= 16'h0000;
            DigitCount          <= 2'd0;
            RomAddress          <= 3'd0;
            MatchedID           <= 1'b0;
            PlayerAddress_to_PH <= 3'd0;
            IdBusy              <= 1'b0;
            IdError             <= 1'b0;
`ifdef ID_HANDLER_GUEST_LOGIN_EN
            IsGuest             <= 1'b0;
`endif
        end else if (LogoutCommand_from_GC) begin
            // Logout wins over everything, including a button press this cycle.
            state               <= ENTRY;
            EnteredId           <= 16'h0000;
            DigitCount          <= 2'd0;
            RomAddress          <= 3'd0;
            MatchedID           <= 1'b0;
            PlayerAddress_to_PH <= 3'd0;
            IdBusy              <= 1'b0;
            IdError             <= 1'b0;
`ifdef ID_HANDLER_GUEST_LOGIN_EN
            IsGuest             <= 1'b0;
`endif
        end else begin
            IdError <= 1'b0;
            case (state)
                ENTRY: begin
                    if (IdButton) begin
                        EnteredId  <= {EnteredId[11:0], IdSwitch};
                        DigitCount <= DigitCount + 2'd1;
                        if (DigitCount == 2'd3) begin
                            state      <= FETCH;
                            RomAddress <= 3'd0;
                            IdBusy     <= 1'b1;
                        end
                    end
                end
                FETCH: begin
`ifdef ID_HANDLER_GUEST_LOGIN_EN
                    if (RomAddress == 3'd0 && EnteredId == 16'h0000) begin
                        state               <= MATCHED;
                        MatchedID           <= 1'b1;
                        IsGuest             <= 1'b1;
                        PlayerAddress_to_PH <= 3'b111;
                        IdBusy              <= 1'b0;
                    end else
`endif
                    state <= CATCH;
                end
                CATCH: begin
                    RomWord <= RomData;
                    state   <= COMPARE;
                end
                COMPARE: begin
                    // Ascending scan, so duplicates resolve to the lowest slot.
                    if (RomWord == EnteredId) begin
                        state               <= MATCHED;
                        MatchedID           <= 1'b1;
                        PlayerAddress_to_PH <= RomAddress;
                        IdBusy              <= 1'b0;
                    end else if (RomAddress == LAST_ADDR) begin
                        state   <= NOMATCH;
                        IdError <= 1'b1;
                        IdBusy  <= 1'b0;
                    end else begin
                        RomAddress <= RomAddress + 3'd1;
                        state      <= FETCH;
                    end
                end
                MATCHED: begin
                    state <= MATCHED;
                end
                NOMATCH: begin
                    state     <= ENTRY;
                    EnteredId <= 16'h0000;
                end
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_handler.sv
// tb/tb_id_handler.sv - self-checking bench for id_handler (NUM_USERS 8 and 3)
module tb_id_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw;
    logic        btn, logout, btnB, logoutB;
    logic [15:0] romData, romDataB;
    logic [2:0]  romAddr, romAddrB, pAddr, pAddrB;
    logic        matched, guest, busy, err;
    logic        matchedB, guestB, busyB, errB;

    logic [15:0] romA [8];
    logic [15:0] romB [8];

    int checks = 0;
    int errors = 0;
    bit badAddrB = 1'b0;

    always #5 clk = ~clk;

    id_handler #(.NUM_USERS(8)) dutA (
        .clk(clk), .rst(rst), .IdSwitch(sw), .IdButton(btn),
        .LogoutCommand_from_GC(logout), .RomData(romData), .RomAddress(romAddr),
        .MatchedID(matched), .PlayerAddress_to_PH(pAddr), .IsGuest(guest),
        .IdBusy(busy), .IdError(err)
    );

    id_handler #(.NUM_USERS(3)) dutB (
        .clk(clk), .rst(rst), .IdSwitch(sw), .IdButton(btnB),
        .LogoutCommand_from_GC(logoutB), .RomData(romDataB), .RomAddress(romAddrB),
        .MatchedID(matchedB), .PlayerAddress_to_PH(pAddrB), .IsGuest(guestB),
        .IdBusy(busyB), .IdError(errB)
    );

    // Synchronous ROMs: data follows the address one cycle later.
    always @(posedge clk) begin
        romData  <= romA[romAddr];
        romDataB <= romB[romAddrB];
    end

    always @(negedge clk) if (romAddrB > 3'd2) badAddrB = 1'b1;

    typedef struct {
        string       name;
        logic [15:0] id;
        bit          m;
        logic [2:0]  a;
        bit          g;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Four presses back to back; returns just after E0 (the edge sampling the 4th press).
    task automatic pressId(input logic [15:0] id, input bit onB);
        for (int d = 3; d >= 0; d--) begin
            @(negedge clk);
            sw = id[d*4 +: 4];
            if (onB) btnB = 1'b1; else btn = 1'b1;
        end
        @(negedge clk);
        btn  = 1'b0;
        btnB = 1'b0;
    endtask

    // Edge count after E0 at which a result first shows; -1 if none within bound.
    task automatic waitLat(input bit onB, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (onB ? (matchedB || errB) : (matched || err)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic doLogout();
        @(negedge clk);
        logout = 1'b1;
        @(negedge clk);
        logout = 1'b0;
        check("logout_matched", matched, 0);
    endtask

    // Reference: first ROM slot whose word equals the ID; three cycles per slot visited.
    task automatic refModel(input logic [15:0] id, output bit m, output logic [2:0] a,
                            output bit g, output int lat);
        m = 0; a = 0; g = 0; lat = 24;
`ifdef ID_HANDLER_GUEST_LOGIN_EN
        if (id == 16'h0000) begin
            m = 1; a = 3'd7; g = 1; lat = 1;
            return;
        end
`endif
        for (int i = 0; i < 8; i++) begin
            if (romA[i] == id) begin
                m = 1; a = 3'(i); lat = 3 * i + 3;
                return;
            end
        end
    endtask

    task automatic runA(input string name, input logic [15:0] id, input bit m,
                        input logic [2:0] a, input bit g, input int lat);
        int got;
        pressId(id, 1'b0);
        waitLat(1'b0, got);
        check({name, "_lat"}, got, lat);
        check({name, "_matched"}, matched, m);
        check({name, "_err"}, err, !m);
        if (m) begin
            check({name, "_addr"}, pAddr, a);
            check({name, "_guest"}, guest, g);
            doLogout();
        end else begin
            @(negedge clk);
            check({name, "_err_pulse"}, err, 0);
            check({name, "_busy_after"}, busy, 0);
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   lat;
        bit   m, g;
        logic [2:0] a;
        logic [15:0] id;

        vecs[0] = '{"id3333", 16'h3333, 1, 3'd2, 0, 9};
        vecs[1] = '{"idABCD", 16'hABCD, 0, 3'd0, 0, 24};
        vecs[2] = '{"id1111", 16'h1111, 1, 3'd0, 0, 3};
        vecs[3] = '{"id8888", 16'h8888, 1, 3'd7, 0, 24};
        vecs[4] = '{"id5555", 16'h5555, 1, 3'd4, 0, 15};
`ifdef ID_HANDLER_GUEST_LOGIN_EN
        vecs[5] = '{"guest0000", 16'h0000, 1, 3'd7, 1, 1};
`else
        vecs[5] = '{"plain0000", 16'h0000, 0, 3'd0, 0, 24};
`endif

        for (int i = 0; i < 8; i++) romA[i] = {4{4'(i + 1)}};
        romB[0] = 16'h1111; romB[1] = 16'h2222; romB[2] = 16'h3333;
        for (int i = 3; i < 8; i++) romB[i] = 16'h1234;

        rst = 1'b1; sw = 4'h0; btn = 1'b0; logout = 1'b0; btnB = 1'b0; logoutB = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_romaddr", romAddr, 0);
        check("rst_matched", matched, 0);
        check("rst_paddr", pAddr, 0);
        check("rst_guest", guest, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            runA(vecs[i].name, vecs[i].id, vecs[i].m, vecs[i].a, vecs[i].g, vecs[i].lat);

        // IdBusy across the whole search for a slot-2 match.
        pressId(16'h3333, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("busy_E%0d", k), busy, k <= 8);
            check($sformatf("matched_E%0d", k), matched, k == 9);
        end
        check("busy_seq_addr", pAddr, 2);

        // Logout together with a button press while matched.
        @(negedge clk);
        logout = 1'b1; btn = 1'b1; sw = 4'h5;
        @(negedge clk);
        logout = 1'b0; btn = 1'b0;
        check("lo_matched", matched, 0);
        check("lo_paddr", pAddr, 0);
        check("lo_romaddr", romAddr, 0);
        check("lo_busy", busy, 0);
        check("lo_err", err, 0);
        check("lo_guest", guest, 0);
        runA("after_logout", 16'h2222, 1, 3'd1, 0, 6);

        // Presses during the search must be ignored.
        pressId(16'h2222, 1'b0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            btn = (k < 4);
            sw  = 4'hF;
            if (matched || err) begin lat = k; break; end
        end
        btn = 1'b0;
        check("btn_in_search_lat", lat, 6);
        check("btn_in_search_addr", pAddr, 1);
        doLogout();

        // Asynchronous reset mid-search.
        pressId(16'h8888, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_romaddr", romAddr, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_matched", matched, 0);
        check("async_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        runA("after_rst", 16'h4444, 1, 3'd3, 0, 12);

        // NUM_USERS=3: slot 3 holds the ID but lies outside the search range.
        pressId(16'h1234, 1'b1);
        waitLat(1'b1, lat);
        check("b_nomatch_lat", lat, 9);
        check("b_nomatch_err", errB, 1);
        check("b_nomatch_matched", matchedB, 0);
        @(negedge clk);
        check("b_err_pulse", errB, 0);
        pressId(16'h3333, 1'b1);
        waitLat(1'b1, lat);
        check("b_match_lat", lat, 9);
        check("b_match_addr", pAddrB, 2);
        check("b_addr_range", badAddrB, 0);

        // Randomised ROM (with a forced duplicate) against the reference model.
        for (int i = 0; i < 8; i++) romA[i] = 16'(($urandom % 16'hFFFF) + 1);
        romA[6] = romA[3];
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 3))
                0:       id = 16'($urandom);
                1:       id = 16'h0000;
                default: id = romA[$urandom_range(0, 7)];
            endcase
            refModel(id, m, a, g, lat);
            runA($sformatf("rand%0d_%h", it, id), id, m, a, g, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
